uart_rx_buffer_ctrl: RTL and testbench

UART_RX_BUFFER_CTRL -- requirements
Module: uart_rx_buffer_ctrl

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_buffer_ctrl_if.sv | 21 ++
 rtl/uart_sync_fifo.sv | 39 +++
 rtl/uart_rx_buffer_ctrl.sv | 122 ++++++++++++
 tb/tb_uart_rx_buffer_ctrl.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared timeout state encodings and timing formula for the UART receive buffer
package uart_pkg;

    typedef enum logic [1:0] {
        T_IDLE    = 2'd0,
        T_ARMED   = 2'd1,
        T_EXPIRED = 2'd2
    } timeout_state_t;

    // Idle timeout spans four complete frames: start + data + stop bits each.
    function automatic int timeout_cycles(input int data_bits, input int cycles_per_bit);
        return 4 * (data_bits + 2) * cycles_per_bit;
    endfunction

endpackage

// File: rtl/uart_rx_buffer_ctrl_if.sv
// rtl/uart_rx_buffer_ctrl_if.sv - push/pop/flush bus between buffer control and circular storage
interface uart_rx_buffer_ctrl_if #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 4
);
    logic                 push;
    logic [DATA_BITS-1:0] push_data;
    logic                 pop;
    logic                 flush;
    logic [DATA_BITS-1:0] pop_data;

    modport master (
        output push, push_data, pop, flush,
        input  pop_data
    );

    modport slave (
        input  push, push_data, pop, flush,
        output pop_data
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - circular storage with wrapping read/write pointers; caller qualifies push/pop
module uart_sync_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    uart_rx_buffer_ctrl_if.slave    bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [DATA_BITS-1:0]  mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (bus.push) wr_ptr <= wr_ptr + PTR_ONE;
            if (bus.pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage is not reset; the occupancy count hides stale entries.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && !bus.flush && bus.push) begin
            mem[wr_ptr] <= bus.push_data;
        end
    end

    assign bus.pop_data = mem[rd_ptr];

endmodule

// File: rtl/uart_rx_buffer_ctrl.sv
// rtl/uart_rx_buffer_ctrl.sv - UART receive buffer: occupancy, overrun and optional idle timeout (UART_RX_TIMEOUT_EN)
module uart_rx_buffer_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS      = 8,
    parameter int DEPTH_LOG2     = 4,
    parameter int CYCLES_PER_BIT = 5208
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_rx_strobe,
    input  logic [DATA_BITS-1:0]  i_rx_data,
    input  logic                  i_rx_busy,
    output logic                  o_valid,
    output logic [DATA_BITS-1:0]  o_data,
    input  logic                  i_ready,
    output logic [DEPTH_LOG2:0]   o_count,
    input  logic                  i_flush,
    output logic                  o_overrun,
    input  logic                  i_clr_overrun,
    output logic                  o_timeout
);
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] COUNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam int TIMEOUT_CYCLES = timeout_cycles(DATA_BITS, CYCLES_PER_BIT);

    logic [DEPTH_LOG2:0] count;
    logic                overrun;
    logic                empty;
    logic                full;
    logic                do_pop;
    logic                do_push;
    logic                drop;

    uart_rx_buffer_ctrl_if #(.DATA_BITS(DATA_BITS), .ADDR_BITS(DEPTH_LOG2)) fifo_bus ();

    uart_sync_fifo #(.DATA_BITS(DATA_BITS), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (fifo_bus.slave)
    );

    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);

    // A pop frees a slot in the same cycle, so a full buffer still accepts a word alongside it.
    assign do_pop  = !i_flush && !empty && i_ready;
    assign do_push = !i_flush && i_rx_strobe && (!full || do_pop);
    assign drop    = !i_flush && i_rx_strobe && full && !do_pop;

    assign fifo_bus.push      = do_push;
    assign fifo_bus.push_data = i_rx_data;
    assign fifo_bus.pop       = do_pop;
    assign fifo_bus.flush     = i_flush;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (i_flush)                count <= '0;
            else if (do_push && !do_pop) count <= count + COUNT_ONE;
            else if (do_pop && !do_push) count <= count - COUNT_ONE;

            if (drop)               overrun <= 1'b1;
            else if (i_clr_overrun) overrun <= 1'b0;
        end
    end

    assign o_valid   = !empty;
    assign o_data    = fifo_bus.pop_data;
    assign o_count   = count;
    assign o_overrun = overrun;

`ifdef UART_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    timeout_state_t        t_state, t_state_next;
    logic [TW-1:0]         t_cnt, t_cnt_next;
    logic                  t_kick;

    assign t_kick = do_push || do_pop || i_flush || i_rx_busy || empty;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            t_state <= T_IDLE;
            t_cnt   <= '0;
        end else begin
            t_state <= t_state_next;
            t_cnt   <= t_cnt_next;
        end
    end

    always_comb begin
        t_state_next = t_state;
        t_cnt_next   = t_cnt;
        if (t_kick) begin
            t_state_next = T_IDLE;
        end else begin
            case (t_state)
                T_IDLE: begin
                    t_state_next = T_ARMED;
                    t_cnt_next   = TW'(TIMEOUT_CYCLES - 1);
                end
                T_ARMED: begin
                    if (t_cnt == '0) t_state_next = T_EXPIRED;
                    else             t_cnt_next   = t_cnt - TW'(1);
                end
                T_EXPIRED: t_state_next = T_EXPIRED;
                default:   t_state_next = T_IDLE;
            endcase
        end
    end

    assign o_timeout = (t_state == T_EXPIRED);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = i_rx_busy ^ (TIMEOUT_CYCLES == 0);
    assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_buffer_ctrl.sv
// tb/tb_uart_rx_buffer_ctrl.sv - scoreboard bench for uart_rx_buffer_ctrl
module tb_uart_rx_buffer_ctrl;
    localparam int DB = 8;
    localparam int DL = 4;
    localparam int CPB = 4;
    localparam int TCYC = 4 * (DB + 2) * CPB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          busy;
    logic          clr;
    logic          o_valid;
    logic [DB-1:0] o_data;
    logic [DL:0]   o_count;
    logic          o_overrun;
    logic          o_timeout;

    int checks = 0;
    int errors = 0;
    int mcount = 0;
    bit movr = 1'b0;
    logic [DB-1:0] exp_q [$];

    uart_rx_buffer_ctrl_if #(.DATA_BITS(DB), .ADDR_BITS(DL)) stim ();
    assign stim.pop_data = o_data;

    uart_rx_buffer_ctrl #(.DATA_BITS(DB), .DEPTH_LOG2(DL), .CYCLES_PER_BIT(CPB)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_rx_strobe   (stim.push),
        .i_rx_data     (stim.push_data),
        .i_rx_busy     (busy),
        .o_valid       (o_valid),
        .o_data        (o_data),
        .i_ready       (stim.pop),
        .o_count       (o_count),
        .i_flush       (stim.flush),
        .o_overrun     (o_overrun),
        .i_clr_overrun (clr),
        .o_timeout     (o_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted pop is compared against the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && !stim.flush && o_valid && stim.pop) begin
            if (exp_q.size() == 0) begin
                chk("pop_unexpected", 1, 0);
            end else begin
                chk("pop_data", int'(o_data), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit s, input logic [DB-1:0] d, input bit r, input bit f, input bit c);
        bit pop_m;
        bit push_m;
        stim.push = s; stim.push_data = d; stim.pop = r; stim.flush = f; clr = c;
        pop_m  = (mcount != 0) && r && !f;
        push_m = s && !f && ((mcount < 16) || pop_m);
        if (s && !f && mcount == 16 && !pop_m) movr = 1'b1;
        else if (c) movr = 1'b0;
        if (f) begin
            mcount = 0;
            exp_q.delete();
        end else begin
            if (push_m) exp_q.push_back(d);
            mcount = mcount + int'(push_m) - int'(pop_m);
        end
        cyc();
        stim.push = 1'b0; stim.pop = 1'b0; stim.flush = 1'b0; clr = 1'b0;
        chk("count", int'(o_count), mcount);
        chk("overrun", int'(o_overrun), int'(movr));
        chk("valid", int'(o_valid), int'(mcount != 0));
    endtask

    task automatic do_reset(input bit s);
        rst_n = 1'b0; stim.push = s; stim.push_data = 8'hEE; stim.pop = 1'b1;
        cyc();
        mcount = 0; movr = 1'b0; exp_q.delete();
        chk("rst_count", int'(o_count), 0);
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_overrun", int'(o_overrun), 0);
        chk("rst_timeout", int'(o_timeout), 0);
        rst_n = 1'b1; stim.push = 1'b0; stim.pop = 1'b0;
    endtask

    initial begin
        logic [DB-1:0] seq [3];
        bit seen;
        seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33;
        rst_n = 1'b0; busy = 1'b0; clr = 1'b0;
        stim.push = 1'b0; stim.push_data = '0; stim.pop = 1'b0; stim.flush = 1'b0;
        cyc();
        do_reset(1'b0);

        // In-order delivery with consumer stalled, then drained
        for (int i = 0; i < 3; i++) step(1'b1, seq[i], 1'b0, 1'b0, 1'b0);
        chk("head_data", int'(o_data), 8'h11);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Fill past capacity: 17th word dropped
        for (int i = 0; i < 17; i++) step(1'b1, 8'h40 + DB'(i), 1'b0, 1'b0, 1'b0);
        chk("full_count", int'(o_count), 16);
        chk("ovr_set", int'(o_overrun), 1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("ovr_clr", int'(o_overrun), 0);
        step(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
        chk("ovr_set_wins", int'(o_overrun), 1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Full buffer: push with pop is accepted, 0xAA leaves 16th
        step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
        chk("full_pushpop_ovr", int'(o_overrun), 0);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("drained", int'(o_count), 0);
        chk("drained_q", exp_q.size(), 0);

        // Interleaved push/pop across pointer wrap
        for (int i = 0; i < 20; i++) step(1'b1, 8'h80 + DB'(i), 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("wrap_empty", int'(o_count), 0);

        // Flush beats coincident push
        for (int i = 0; i < 5; i++) step(1'b1, 8'hC0 + DB'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hCF, 1'b1, 1'b1, 1'b0);
        chk("flush_count", int'(o_count), 0);
        step(1'b1, 8'hD1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Reset mid-stream with overrun pending
        for (int i = 0; i < 17; i++) step(1'b1, 8'h10 + DB'(i), 1'b0, 1'b0, 1'b0);
        do_reset(1'b1);
        step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        chk("post_rst_head", int'(o_data), 8'h5A);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Idle timeout with a single held word
        step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < TCYC - 20; i++) cyc();
        chk("timeout_early", int'(o_timeout), 0);
`ifdef UART_RX_TIMEOUT_EN
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cyc();
            seen = o_timeout;
        end
        chk("timeout_set", int'(seen), 1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("timeout_clr", int'(o_timeout), 0);
`else
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            cyc();
            if (o_timeout) seen = 1'b1;
        end
        chk("timeout_off", int'(seen), 0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
`endif
        chk("final_q", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
